// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Imported by the top level and the clear sequencer.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_t;

  function automatic int unsigned rf_aw(int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned rf_first_addr(bit zero_reg);
    return zero_reg ? 1 : 0;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Sequential clear engine: zeroes one entry per cycle,
// then holds ready high until rst or clear_req.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = rf_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] FIRST =
    AW'(rf_first_addr(ZERO_REG));
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_t     state;
  logic [AW-1:0] clr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      clr_ptr <= FIRST;
      ready   <= 1'b0;
    end else begin
      case (state)
        RF_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST) begin
            state <= RF_RUN;
            ready <= 1'b1;
          end
        end
        RF_RUN: begin
          if (clear_req) begin
            state   <= RF_CLEAR;
            clr_ptr <= FIRST;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= RF_CLEAR;
          clr_ptr <= FIRST;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == RF_CLEAR) && !rst;
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass,
// highest-port-wins writes and a sequential clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = rf_aw(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_req,
  output logic                   ready,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_data,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [XLEN-1:0] mem [0:DEPTH-1];

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic [AW-1:0]   wa [NUM_WR];
  logic [XLEN-1:0] wd [NUM_WR];
  logic [NUM_WR-1:0] w_ok;
  logic [NUM_WR-1:0] w_win;

  regfile_clr_seq #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_clr (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .ready     (ready),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // In range and not the hardwired zero entry
  function automatic logic legal_addr(
    input logic [AW-1:0] a
  );
    return ({1'b0, a} < DEPTH_W) &&
           !(ZERO_REG && (a == '0));
  endfunction

  for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
    logic win;

    assign wa[p] = wr_addr[p*AW +: AW];
    assign wd[p] = wr_data[p*XLEN +: XLEN];

    assign w_ok[p] = ready && !clear_req &&
                     wr_en[p] && legal_addr(wa[p]);

    // A higher port to the same address shadows this one
    always_comb begin
      win = w_ok[p];
      for (int q = p + 1; q < NUM_WR; q++) begin
        if (w_ok[q] && (wa[q] == wa[p])) win = 1'b0;
      end
    end

    assign w_win[p] = win;
  end

  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_addr] <= '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (w_win[p]) mem[wa[p]] <= wd[p];
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = rs_addr[r*AW +: AW];

    always_comb begin
      rd = '0;
      if (ready && legal_addr(ra)) begin
        rd = mem[ra];
        if (BYPASS) begin
          for (int p = 0; p < NUM_WR; p++) begin
            if (w_ok[p] && (wa[p] == ra)) rd = wd[p];
          end
        end
      end
    end

    assign rs_data[r*XLEN +: XLEN] = rd;
  end

endmodule
